// File: rtl/ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_pipeline
//  Description : Control-path pipeline for a 5-stage MIPS core. It carries the
//                decoded control bits from ID through the ID/EX, EX/MEM and
//                MEM/WB registers. It detects load-use hazards (stall),
//                resolves beq/bne/bgtz in EX (flush) and drives the operand
//                forwarding selects.
//  Ports       : clk, reset            clock, synchronous active-high reset
//                id_*                  decoded control and register fields (ID)
//                ex_zero, ex_gtz       branch condition flags from the EX ALU
//                stall, flush          hazard outputs (combinational)
//                ex_alu_src, ex_alu_op ID/EX register contents
//                fwd_a, fwd_b          operand selects: 00 reg, 10 MEM, 01 WB
//                mem_read, mem_write   EX/MEM register contents
//                wb_mem_to_reg, wb_reg_write, wb_dest   MEM/WB register contents
//  Revision    : 1.0  initial release
// ============================================================================
module ctrl_pipeline #(
   parameter int REG_ADDR_W = 5,
   parameter int ALU_OP_W   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic                  id_reg_dst,
   input  logic                  id_alu_src,
   input  logic                  id_mem_to_reg,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic [ALU_OP_W-1:0]   id_alu_op,
   input  logic                  id_beq,
   input  logic                  id_bne,
   input  logic                  id_bgtz,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_zero,
   input  logic                  ex_gtz,
   output logic                  stall,
   output logic                  flush,
   output logic                  ex_alu_src,
   output logic [ALU_OP_W-1:0]   ex_alu_op,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  wb_mem_to_reg,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_dest
);

   localparam logic [1:0]            c_FWD_REG = 2'b00;
   localparam logic [1:0]            c_FWD_MEM = 2'b10;
   localparam logic [1:0]            c_FWD_WB  = 2'b01;
   localparam logic [REG_ADDR_W-1:0] c_REG_ZERO = '0;

   // ID/EX register
   logic                  r_ex_valid, r_ex_reg_dst, r_ex_alu_src, r_ex_mem_to_reg;
   logic                  r_ex_reg_write, r_ex_mem_read, r_ex_mem_write;
   logic [ALU_OP_W-1:0]   r_ex_alu_op;
   logic                  r_ex_beq, r_ex_bne, r_ex_bgtz;
   logic [REG_ADDR_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd;

   // EX/MEM register
   logic                  r_mem_valid, r_mem_mem_to_reg, r_mem_reg_write;
   logic                  r_mem_mem_read, r_mem_mem_write;
   logic [REG_ADDR_W-1:0] r_mem_dest;

   // MEM/WB register
   logic                  r_wb_valid, r_wb_mem_to_reg, r_wb_reg_write;
   logic [REG_ADDR_W-1:0] r_wb_dest;

   logic                  w_ex_is_branch;
   logic [REG_ADDR_W-1:0] w_ex_dest;
   logic                  w_rt_is_src;
   logic                  w_load_use;
   logic                  w_taken;
   logic                  w_mem_fwd_ok;
   logic                  w_wb_fwd_ok;

   assign w_ex_is_branch = r_ex_beq | r_ex_bne | r_ex_bgtz;
   assign w_ex_dest      = r_ex_reg_dst ? r_ex_rd : r_ex_rt;

   // rt is only a true source for R-types, stores and compare branches.
   assign w_rt_is_src = id_reg_dst | id_mem_write | id_beq | id_bne;
   assign w_load_use  = r_ex_valid & r_ex_mem_read & (r_ex_rt != c_REG_ZERO) &
                        ((r_ex_rt == id_rs) | ((r_ex_rt == id_rt) & w_rt_is_src));

   assign w_taken = r_ex_valid & ((r_ex_beq  &  ex_zero) |
                                  (r_ex_bne  & ~ex_zero) |
                                  (r_ex_bgtz &  ex_gtz));

   // A taken branch squashes the ID instruction anyway, so it overrides stall.
   assign flush = w_taken;
   assign stall = w_load_use & ~w_taken;

   // Writes to $0 are architecturally discarded and must never be forwarded.
   assign w_mem_fwd_ok = r_mem_valid & r_mem_reg_write & (r_mem_dest != c_REG_ZERO);
   assign w_wb_fwd_ok  = r_wb_valid  & r_wb_reg_write  & (r_wb_dest  != c_REG_ZERO);

   always_comb begin
      fwd_a = c_FWD_REG;
      fwd_b = c_FWD_REG;
      if (r_ex_valid) begin
         if (w_mem_fwd_ok && (r_mem_dest == r_ex_rs))      fwd_a = c_FWD_MEM;
         else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rs))   fwd_a = c_FWD_WB;
         if (w_mem_fwd_ok && (r_mem_dest == r_ex_rt))      fwd_b = c_FWD_MEM;
         else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rt))   fwd_b = c_FWD_WB;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex_valid       <= 1'b0;
         r_ex_reg_dst     <= 1'b0;
         r_ex_alu_src     <= 1'b0;
         r_ex_mem_to_reg  <= 1'b0;
         r_ex_reg_write   <= 1'b0;
         r_ex_mem_read    <= 1'b0;
         r_ex_mem_write   <= 1'b0;
         r_ex_alu_op      <= '0;
         r_ex_beq         <= 1'b0;
         r_ex_bne         <= 1'b0;
         r_ex_bgtz        <= 1'b0;
         r_ex_rs          <= '0;
         r_ex_rt          <= '0;
         r_ex_rd          <= '0;
         r_mem_valid      <= 1'b0;
         r_mem_mem_to_reg <= 1'b0;
         r_mem_reg_write  <= 1'b0;
         r_mem_mem_read   <= 1'b0;
         r_mem_mem_write  <= 1'b0;
         r_mem_dest       <= '0;
         r_wb_valid       <= 1'b0;
         r_wb_mem_to_reg  <= 1'b0;
         r_wb_reg_write   <= 1'b0;
         r_wb_dest        <= '0;
      end else begin
         // ID/EX: insert a bubble on a load-use stall or a taken branch
         if (w_load_use | w_taken) begin
            r_ex_valid      <= 1'b0;
            r_ex_reg_dst    <= 1'b0;
            r_ex_alu_src    <= 1'b0;
            r_ex_mem_to_reg <= 1'b0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_mem_write  <= 1'b0;
            r_ex_alu_op     <= '0;
            r_ex_beq        <= 1'b0;
            r_ex_bne        <= 1'b0;
            r_ex_bgtz       <= 1'b0;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_ex_rd         <= '0;
         end else begin
            r_ex_valid      <= id_valid;
            r_ex_reg_dst    <= id_reg_dst;
            r_ex_alu_src    <= id_alu_src;
            r_ex_mem_to_reg <= id_mem_to_reg;
            r_ex_reg_write  <= id_reg_write;
            r_ex_mem_read   <= id_mem_read;
            r_ex_mem_write  <= id_mem_write;
            r_ex_alu_op     <= id_alu_op;
            r_ex_beq        <= id_beq;
            r_ex_bne        <= id_bne;
            r_ex_bgtz       <= id_bgtz;
            r_ex_rs         <= id_rs;
            r_ex_rt         <= id_rt;
            r_ex_rd         <= id_rd;
         end

         // EX/MEM: a branch never writes the register file or memory
         r_mem_valid      <= r_ex_valid;
         r_mem_mem_to_reg <= r_ex_mem_to_reg;
         r_mem_reg_write  <= r_ex_reg_write & ~w_ex_is_branch;
         r_mem_mem_read   <= r_ex_mem_read;
         r_mem_mem_write  <= r_ex_mem_write & ~w_ex_is_branch;
         r_mem_dest       <= w_ex_dest;

         // MEM/WB
         r_wb_valid       <= r_mem_valid;
         r_wb_mem_to_reg  <= r_mem_mem_to_reg;
         r_wb_reg_write   <= r_mem_reg_write;
         r_wb_dest        <= r_mem_dest;
      end
   end

   assign ex_alu_src    = r_ex_valid & r_ex_alu_src;
   assign ex_alu_op     = r_ex_valid ? r_ex_alu_op : '0;
   assign mem_read      = r_mem_valid & r_mem_mem_read;
   assign mem_write     = r_mem_valid & r_mem_mem_write;
   assign wb_mem_to_reg = r_wb_valid & r_wb_mem_to_reg;
   assign wb_reg_write  = w_wb_fwd_ok;
   assign wb_dest       = r_wb_valid ? r_wb_dest : '0;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipeline.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ctrl_pipeline
//  Description : Self-checking bench for ctrl_pipeline. Directed scenarios
//                followed by randomized instruction streams, all compared
//                against an instruction-level model of the three stages.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ctrl_pipeline;

   typedef struct packed {
      logic       valid;
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic [1:0] alu_op;
      logic       beq;
      logic       bne;
      logic       bgtz;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
   } inst_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
   logic       id_mem_read, id_mem_write, id_beq, id_bne, id_bgtz;
   logic [1:0] id_alu_op;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       ex_zero, ex_gtz;
   logic       stall, flush, ex_alu_src, mem_read, mem_write;
   logic       wb_mem_to_reg, wb_reg_write;
   logic [1:0] ex_alu_op, fwd_a, fwd_b;
   logic [4:0] wb_dest;

   int total = 0;
   int bad   = 0;

   // model state: the instruction held in each stage
   inst_t m_ex, m_mem, m_wb;
   inst_t cur_id;
   logic  cur_rst;
   logic  exp_stall, exp_taken;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_ADDR_W(5), .ALU_OP_W(2)) dut (
      .clk(clk), .reset(reset),
      .id_valid(id_valid), .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src),
      .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
      .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .id_alu_op(id_alu_op), .id_beq(id_beq), .id_bne(id_bne), .id_bgtz(id_bgtz),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .ex_zero(ex_zero), .ex_gtz(ex_gtz),
      .stall(stall), .flush(flush), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_read(mem_read), .mem_write(mem_write),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- instruction constructors ----------------
   function automatic inst_t nop();
      inst_t i = '0;
      return i;
   endfunction
   function automatic inst_t r_type(input logic [4:0] rs, rt, rd);
      inst_t i = '0;
      i.valid = 1; i.reg_dst = 1; i.reg_write = 1; i.alu_op = 2'b10;
      i.rs = rs; i.rt = rt; i.rd = rd;
      return i;
   endfunction
   function automatic inst_t lw(input logic [4:0] rs, rt);
      inst_t i = '0;
      i.valid = 1; i.alu_src = 1; i.mem_to_reg = 1; i.reg_write = 1; i.mem_read = 1;
      i.rs = rs; i.rt = rt;
      return i;
   endfunction
   function automatic inst_t sw(input logic [4:0] rs, rt);
      inst_t i = '0;
      i.valid = 1; i.alu_src = 1; i.mem_write = 1; i.rs = rs; i.rt = rt;
      return i;
   endfunction
   function automatic inst_t addi(input logic [4:0] rs, rt);
      inst_t i = '0;
      i.valid = 1; i.alu_src = 1; i.reg_write = 1; i.rs = rs; i.rt = rt;
      return i;
   endfunction
   function automatic inst_t branch(input int kind, input logic [4:0] rs, rt);
      inst_t i = '0;
      i.valid = 1; i.alu_op = 2'b01; i.rs = rs; i.rt = rt;
      i.beq = (kind == 0); i.bne = (kind == 1); i.bgtz = (kind == 2);
      return i;
   endfunction

   // ---------------- reference model ----------------
   function automatic logic is_branch(input inst_t i);
      return i.beq | i.bne | i.bgtz;
   endfunction
   function automatic logic [4:0] dest_of(input inst_t i);
      return i.reg_dst ? i.rd : i.rt;
   endfunction
   // true when the stage's instruction will really write a non-zero register
   function automatic logic rf_writer(input inst_t i);
      return i.valid && i.reg_write && !is_branch(i) && dest_of(i) != 5'd0;
   endfunction
   function automatic logic [1:0] model_fwd(input logic [4:0] src);
      if (!m_ex.valid) return 2'b00;
      if (rf_writer(m_mem) && dest_of(m_mem) == src) return 2'b10;
      if (rf_writer(m_wb) && dest_of(m_wb) == src) return 2'b01;
      return 2'b00;
   endfunction

   // drive ID inputs, let them settle, compare every output against the model
   task automatic apply(input inst_t id, input logic rst, input logic zero, input logic gtz);
      logic lu;
      logic rt_used;
      cur_id = id; cur_rst = rst;
      reset = rst; ex_zero = zero; ex_gtz = gtz;
      id_valid = id.valid; id_reg_dst = id.reg_dst; id_alu_src = id.alu_src;
      id_mem_to_reg = id.mem_to_reg; id_reg_write = id.reg_write;
      id_mem_read = id.mem_read; id_mem_write = id.mem_write; id_alu_op = id.alu_op;
      id_beq = id.beq; id_bne = id.bne; id_bgtz = id.bgtz;
      id_rs = id.rs; id_rt = id.rt; id_rd = id.rd;
      #1;
      exp_taken = m_ex.valid && ((m_ex.beq && zero) || (m_ex.bne && !zero) || (m_ex.bgtz && gtz));
      rt_used   = id.reg_dst || id.mem_write || id.beq || id.bne;
      lu        = m_ex.valid && m_ex.mem_read && m_ex.rt != 5'd0 &&
                  (m_ex.rt == id.rs || (m_ex.rt == id.rt && rt_used));
      exp_stall = lu && !exp_taken;
      check_val("stall",         32'(stall),         32'(exp_stall));
      check_val("flush",         32'(flush),         32'(exp_taken));
      check_val("ex_alu_src",    32'(ex_alu_src),    32'(m_ex.valid & m_ex.alu_src));
      check_val("ex_alu_op",     32'(ex_alu_op),     m_ex.valid ? 32'(m_ex.alu_op) : 32'd0);
      check_val("fwd_a",         32'(fwd_a),         32'(model_fwd(m_ex.rs)));
      check_val("fwd_b",         32'(fwd_b),         32'(model_fwd(m_ex.rt)));
      check_val("mem_read",      32'(mem_read),      32'(m_mem.valid & m_mem.mem_read));
      check_val("mem_write",     32'(mem_write),     32'(m_mem.valid & m_mem.mem_write & ~is_branch(m_mem)));
      check_val("wb_mem_to_reg", 32'(wb_mem_to_reg), 32'(m_wb.valid & m_wb.mem_to_reg));
      check_val("wb_reg_write",  32'(wb_reg_write),  32'(rf_writer(m_wb)));
      check_val("wb_dest",       32'(wb_dest),       m_wb.valid ? 32'(dest_of(m_wb)) : 32'd0);
   endtask

   // one clock edge; the model advances its instructions by one stage
   task automatic clock();
      @(posedge clk);
      if (cur_rst) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
      end else begin
         m_wb  = m_mem;
         m_mem = m_ex;
         m_ex  = (exp_stall || exp_taken) ? nop() : cur_id;
      end
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] rv;
      inst_t ri;
      m_ex = '0; m_mem = '0; m_wb = '0;
      @(negedge clk);
      apply(nop(), 1, 0, 0); clock();

      // reset with a full pipe
      apply(r_type(1, 2, 3), 0, 0, 0); clock();
      apply(r_type(1, 2, 4), 0, 0, 0); clock();
      apply(r_type(1, 2, 6), 0, 0, 0); clock();
      apply(nop(), 1, 0, 0); clock();
      apply(nop(), 0, 0, 0);
      check_val("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
      check_val("rst_wb_dest",      32'(wb_dest),      32'd0);
      check_val("rst_ex_alu_op",    32'(ex_alu_op),    32'd0);
      clock();

      // R-type rd=5 reaches WB three clocks later
      apply(r_type(1, 2, 5), 0, 0, 0); clock();
      apply(nop(), 0, 0, 0); clock();
      apply(nop(), 0, 0, 0); clock();
      apply(nop(), 0, 0, 0);
      check_val("rtype_wb_reg_write", 32'(wb_reg_write), 32'd1);
      check_val("rtype_wb_dest",      32'(wb_dest),      32'd5);
      clock();

      // LW rt=3 then ADD rs=3: one stall cycle, then WB forwarding
      apply(lw(1, 3), 0, 0, 0); clock();
      apply(r_type(3, 4, 7), 0, 0, 0);
      check_val("lu_stall_on", 32'(stall), 32'd1);
      clock();
      apply(r_type(3, 4, 7), 0, 0, 0);
      check_val("lu_stall_off", 32'(stall), 32'd0);
      check_val("lu_bubble_alu_op", 32'(ex_alu_op), 32'd0);
      clock();
      apply(nop(), 0, 0, 0);
      check_val("lu_fwd_a", 32'(fwd_a), 32'd1);
      clock();

      // BEQ taken squashes, BEQ not taken lets ID advance
      apply(branch(0, 1, 2), 0, 0, 0); clock();
      apply(r_type(4, 5, 6), 0, 1, 0);
      check_val("beq_taken_flush", 32'(flush), 32'd1);
      clock();
      apply(nop(), 0, 0, 0);
      check_val("beq_taken_bubble", 32'(ex_alu_op), 32'd0);
      clock();
      apply(branch(0, 1, 2), 0, 0, 0); clock();
      apply(r_type(4, 5, 6), 0, 0, 0);
      check_val("beq_nt_flush", 32'(flush), 32'd0);
      clock();
      apply(nop(), 0, 0, 0);
      check_val("beq_nt_advance", 32'(ex_alu_op), 32'd2);
      clock();

      // MEM beats WB when both write the same register
      apply(r_type(1, 1, 2), 0, 0, 0); clock();
      apply(r_type(3, 3, 2), 0, 0, 0); clock();
      apply(r_type(2, 4, 8), 0, 0, 0); clock();
      apply(nop(), 0, 0, 0);
      check_val("mem_over_wb_fwd_a", 32'(fwd_a), 32'd2);
      clock();

      // writes to $0 never forward nor reach the register file
      apply(addi(1, 0), 0, 0, 0); clock();
      apply(r_type(0, 0, 9), 0, 0, 0); clock();
      apply(nop(), 0, 0, 0);
      check_val("r0_fwd_a", 32'(fwd_a), 32'd0);
      clock();
      apply(nop(), 0, 0, 0);
      check_val("r0_wb_reg_write", 32'(wb_reg_write), 32'd0);
      clock();

      // randomized streams with a small register range to provoke hazards
      for (int n = 0; n < 600; n++) begin
         logic [4:0] a, b, c;
         a = 5'($urandom_range(0, 5));
         b = 5'($urandom_range(0, 5));
         c = 5'($urandom_range(0, 5));
         case ($urandom_range(0, 7))
            0: ri = r_type(a, b, c);
            1: ri = lw(a, b);
            2: ri = sw(a, b);
            3: ri = addi(a, b);
            4: ri = branch(int'($urandom_range(0, 2)), a, b);
            5: ri = nop();
            6: ri = lw(a, b);
            default: begin
               rv = $urandom();
               ri = rv[26:0];
               ri.rs = a; ri.rt = b; ri.rd = c;
            end
         endcase
         if ($urandom_range(0, 9) == 0) ri.valid = 1'b0;
         apply(ri, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         clock();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
